// File: rtl/seg_display_sched_pkg.sv
// seg_display_sched_pkg: definitions shared by the display scheduler files.
//   state_t       - scheduler states IDLE / ROTATE / URGENT / GAP
//   act_t         - transition chosen in a cycle
//   GAP_CYCLES    - blank cycles inserted on a source change (SEG_SCHED_GAP_EN builds)
//   BLANK_BYTE    - byte driven while nothing is shown
//   idx_width()   - width of a source index, never below 1
package seg_display_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        URGENT = 2'd2,
        GAP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_URGENT = 2'd1,
        ACT_ROTATE = 2'd2,
        ACT_IDLE   = 2'd3
    } act_t;

    localparam int         GAP_CYCLES = 1024;
    localparam logic [7:0] BLANK_BYTE = 8'h00;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_sched_if.sv
// seg_display_sched_if: source and display-side signals of the scheduler.
//   src_data    - byte of source i at [8*i+7:8*i]
//   src_valid   - source i wants rotation slots (level)
//   urg_req     - source i requests urgent display (level, held until ack)
//   urg_ack     - one-cycle pulse: request i accepted, its byte captured
//   disp_byte   - byte to the display driver
//   disp_src    - index of the source currently shown
//   disp_urgent - high while an urgent value is shown
//   disp_blank  - high when nothing is shown
// master: producer/driver side, slave: the scheduler.
interface seg_display_sched_if #(
    parameter int N_SRC = 4
);
    localparam int IW = seg_display_sched_pkg::idx_width(N_SRC);

    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_valid;
    logic [N_SRC-1:0]   urg_req;
    logic [N_SRC-1:0]   urg_ack;
    logic [7:0]         disp_byte;
    logic [IW-1:0]      disp_src;
    logic               disp_urgent;
    logic               disp_blank;

    modport master (
        output src_data, src_valid, urg_req,
        input  urg_ack, disp_byte, disp_src, disp_urgent, disp_blank
    );

    modport slave (
        input  src_data, src_valid, urg_req,
        output urg_ack, disp_byte, disp_src, disp_urgent, disp_blank
    );

endinterface

// File: rtl/seg_display_sched_rr_pick.sv
// seg_display_sched_rr_pick: combinational round-robin finder.
//   req   - request mask
//   start - index the search starts from
//   incl  - 1: start itself is a candidate; 0: search begins after start
//   found - some request bit matched
//   idx   - first matching index walking upward from start with wrap
// With start=0 and incl=1 this is a plain lowest-index priority encoder.
module seg_display_sched_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          incl,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk candidates from the farthest back to the nearest so the nearest hit wins.
    always_comb begin
        int            c;
        logic [IW-1:0] ci;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c     = int'(start) + k + (incl ? 32'sd0 : 32'sd1);
            c     = (c >= N) ? (c - N) : c;
            ci    = IW'(c);
            found = found | req[ci];
            idx   = req[ci] ? ci : idx;
        end
    end

endmodule

// File: rtl/seg_display_sched.sv
// seg_display_sched: chooses which of N_SRC byte sources drives the shared
// two-digit hex display. Valid sources rotate on a dwell timer; urgent
// requests (acked with a one-cycle pulse) pre-empt rotation for a fixed hold.
//   clk, rst - clock, synchronous active-high reset
//   bus      - seg_display_sched_if.slave (sources in, display/ack out)
// All outputs are registered (1-cycle latency).
// Build option: SEG_SCHED_GAP_EN inserts GAP_CYCLES blank cycles on every
// source change; without it changes take effect on the next edge and
// disp_blank is high only in IDLE.
module seg_display_sched
    import seg_display_sched_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int DWELL_CYCLES  = 12000000,
    parameter int URGENT_CYCLES = 24000000
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_sched_if.slave bus
);

    localparam int IW   = idx_width(N_SRC);
    localparam int MAXC = (DWELL_CYCLES > URGENT_CYCLES) ? DWELL_CYCLES : URGENT_CYCLES;
    localparam int TW   = $clog2(MAXC);
    localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] URGENT_LAST = TW'(URGENT_CYCLES - 1);

    state_t           state_r, state_s;
    act_t             act_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic [IW-1:0]    rr_ptr_r, rr_ptr_s;   // rotation index, kept through URGENT
    logic [IW-1:0]    rot_idx_s;
    logic [7:0]       disp_byte_r, disp_byte_s;
    logic [IW-1:0]    disp_src_r, disp_src_s;
    logic             disp_urgent_r, disp_urgent_s;
    logic             disp_blank_r, disp_blank_s;
    logic [N_SRC-1:0] urg_ack_r, urg_ack_s;
    logic [7:0]       src_bytes_s [N_SRC];
    logic             sel_found_s, urg_found_s;
    logic [IW-1:0]    sel_idx_s, urg_idx_s;

`ifdef SEG_SCHED_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES);
    logic [GW-1:0] gap_cnt_r, gap_cnt_s;
    state_t        gap_tgt_r, gap_tgt_s;
    logic [7:0]    urg_byte_r, urg_byte_s;
`endif

    for (genvar g = 0; g < N_SRC; g++) begin : g_bytes
        assign src_bytes_s[g] = bus.src_data[8*g +: 8];
    end

    // IDLE searches at/after the pointer; ROTATE and URGENT exit search strictly after it.
    seg_display_sched_rr_pick #(.N(N_SRC), .IW(IW)) u_sel_pick (
        .req   (bus.src_valid),
        .start (rr_ptr_r),
        .incl  (state_r == IDLE),
        .found (sel_found_s),
        .idx   (sel_idx_s)
    );

    seg_display_sched_rr_pick #(.N(N_SRC), .IW(IW)) u_urg_pick (
        .req   (bus.urg_req),
        .start ({IW{1'b0}}),
        .incl  (1'b1),
        .found (urg_found_s),
        .idx   (urg_idx_s)
    );

    // Next state, timer and next registered outputs.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        rr_ptr_s      = rr_ptr_r;
        rot_idx_s     = rr_ptr_r;
        act_s         = ACT_HOLD;
        disp_byte_s   = disp_byte_r;
        disp_src_s    = disp_src_r;
        disp_urgent_s = disp_urgent_r;
        disp_blank_s  = disp_blank_r;
        urg_ack_s     = '0;
`ifdef SEG_SCHED_GAP_EN
        gap_cnt_s     = gap_cnt_r;
        gap_tgt_s     = gap_tgt_r;
        urg_byte_s    = urg_byte_r;
`endif
        case (state_r)
            IDLE: begin
                if (urg_found_s) begin
                    act_s = ACT_URGENT;
                end else if (sel_found_s) begin
                    act_s     = ACT_ROTATE;
                    rot_idx_s = sel_idx_s;
                end else begin
                    act_s = ACT_IDLE;
                end
            end
            ROTATE: begin
                // Urgent wins over dwell expiry; a dropped source advances immediately.
                if (urg_found_s) begin
                    act_s = ACT_URGENT;
                end else if (!bus.src_valid[rr_ptr_r] || (timer_r >= DWELL_LAST)) begin
                    if (sel_found_s) begin
                        act_s     = ACT_ROTATE;
                        rot_idx_s = sel_idx_s;
                    end else begin
                        act_s = ACT_IDLE;
                    end
                end else begin
                    timer_s     = timer_r + TW'(1);
                    disp_byte_s = src_bytes_s[rr_ptr_r];
                end
            end
            URGENT: begin
                if (timer_r >= URGENT_LAST) begin
                    if (urg_found_s) begin
                        act_s = ACT_URGENT;
                    end else if (bus.src_valid[rr_ptr_r]) begin
                        act_s     = ACT_ROTATE;
                        rot_idx_s = rr_ptr_r;
                    end else if (sel_found_s) begin
                        act_s     = ACT_ROTATE;
                        rot_idx_s = sel_idx_s;
                    end else begin
                        act_s = ACT_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
`ifdef SEG_SCHED_GAP_EN
            GAP: begin
                // Requests are not arbitrated until the blank interval ends.
                if (gap_cnt_r >= GW'(GAP_CYCLES - 1)) begin
                    state_s      = gap_tgt_r;
                    timer_s      = '0;
                    disp_blank_s = 1'b0;
                    disp_byte_s  = (gap_tgt_r == URGENT) ? urg_byte_r : src_bytes_s[rr_ptr_r];
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
`endif
            default: begin
                act_s = ACT_IDLE;
            end
        endcase

        case (act_s)
            ACT_URGENT: begin
                urg_ack_s     = N_SRC'(1'b1) << urg_idx_s;
                disp_src_s    = urg_idx_s;
                disp_urgent_s = 1'b1;
                timer_s       = '0;
`ifdef SEG_SCHED_GAP_EN
                urg_byte_s    = src_bytes_s[urg_idx_s];
                state_s       = GAP;
                gap_tgt_s     = URGENT;
                gap_cnt_s     = '0;
                disp_blank_s  = 1'b1;
                disp_byte_s   = BLANK_BYTE;
`else
                state_s       = URGENT;
                disp_blank_s  = 1'b0;
                disp_byte_s   = src_bytes_s[urg_idx_s];
`endif
            end
            ACT_ROTATE: begin
                rr_ptr_s      = rot_idx_s;
                disp_src_s    = rot_idx_s;
                disp_urgent_s = 1'b0;
                timer_s       = '0;
`ifdef SEG_SCHED_GAP_EN
                // Re-showing the same rotating source, or starting from IDLE, needs no gap.
                if ((state_r == URGENT) || ((state_r == ROTATE) && (rot_idx_s != rr_ptr_r))) begin
                    state_s      = GAP;
                    gap_tgt_s    = ROTATE;
                    gap_cnt_s    = '0;
                    disp_blank_s = 1'b1;
                    disp_byte_s  = BLANK_BYTE;
                end else begin
                    state_s      = ROTATE;
                    disp_blank_s = 1'b0;
                    disp_byte_s  = src_bytes_s[rot_idx_s];
                end
`else
                state_s       = ROTATE;
                disp_blank_s  = 1'b0;
                disp_byte_s   = src_bytes_s[rot_idx_s];
`endif
            end
            ACT_IDLE: begin
                state_s       = IDLE;
                timer_s       = '0;
                disp_urgent_s = 1'b0;
                disp_blank_s  = 1'b1;
                disp_byte_s   = BLANK_BYTE;
            end
            default: begin
            end
        endcase
    end

    // State, timer, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            timer_r       <= '0;
            rr_ptr_r      <= '0;
            disp_byte_r   <= BLANK_BYTE;
            disp_src_r    <= '0;
            disp_urgent_r <= 1'b0;
            disp_blank_r  <= 1'b1;
            urg_ack_r     <= '0;
`ifdef SEG_SCHED_GAP_EN
            gap_cnt_r     <= '0;
            gap_tgt_r     <= IDLE;
            urg_byte_r    <= BLANK_BYTE;
`endif
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            rr_ptr_r      <= rr_ptr_s;
            disp_byte_r   <= disp_byte_s;
            disp_src_r    <= disp_src_s;
            disp_urgent_r <= disp_urgent_s;
            disp_blank_r  <= disp_blank_s;
            urg_ack_r     <= urg_ack_s;
`ifdef SEG_SCHED_GAP_EN
            gap_cnt_r     <= gap_cnt_s;
            gap_tgt_r     <= gap_tgt_s;
            urg_byte_r    <= urg_byte_s;
`endif
        end
    end

    assign bus.urg_ack     = urg_ack_r;
    assign bus.disp_byte   = disp_byte_r;
    assign bus.disp_src    = disp_src_r;
    assign bus.disp_urgent = disp_urgent_r;
    assign bus.disp_blank  = disp_blank_r;

endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: directed bench for seg_display_sched with
// N_SRC=4, DWELL_CYCLES=8, URGENT_CYCLES=16 (SEG_SCHED_GAP_EN undefined).
// Each step pushes the per-cycle expected outputs to a queue; drain()
// advances one clock per queued entry and compares after the edge.
module tb_seg_display_sched;

    localparam int N = 4;
    localparam int D = 8;
    localparam int U = 16;

    logic clk = 1'b0;
    logic rst;

    seg_display_sched_if #(.N_SRC(N)) bus ();

    seg_display_sched #(
        .N_SRC         (N),
        .DWELL_CYCLES  (D),
        .URGENT_CYCLES (U)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Packed view: {disp_byte[15:8], disp_src[7:6], disp_urgent[5], disp_blank[4], urg_ack[3:0]}
    typedef struct {
        string       tag;
        logic [15:0] val;
        logic [15:0] mask;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input int n, input logic [7:0] b, input logic [1:0] s,
                        input logic u, input logic bl, input logic [3:0] a, input logic chk_src);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag  = tag;
            e.val  = {b, s, u, bl, a};
            e.mask = chk_src ? 16'hFFFF : 16'hFF3F;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sbq.size() > 0) begin
            @(posedge clk);
            #1;
            e   = sbq.pop_front();
            obs = {bus.disp_byte, bus.disp_src, bus.disp_urgent, bus.disp_blank, bus.urg_ack};
            checks++;
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h (mask %h)", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.src_data  = '0;
        bus.src_valid = '0;
        bus.urg_req   = '0;

        // Reset values
        push("reset", 2, 8'h00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        drain();
        rst = 1'b0;

        // Nothing valid: stays blank, no acks
        push("idle_empty", 10, 8'h00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        drain();

        // Rotation over 4'b1011, source 2 skipped, 8 cycles each
        bus.src_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.src_valid = 4'b1011;
        push("rot_s0",  D, 8'h11, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("rot_s1",  D, 8'h22, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("rot_s3",  D, 8'h44, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("rot2_s0", D, 8'h11, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("rot2_s1", 3, 8'h22, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drain();

        // Urgent pre-empt while rotating on source 1
        bus.urg_req = 4'b1100;
        push("urg_ack2", 1, 8'h33, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b1);
        drain();
        bus.src_data[23:16] = 8'h5A;     // captured byte must stay frozen
        bus.urg_req         = 4'b1000;
        push("urg_hold2", U - 1, 8'h33, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1);
        push("urg_ack3",  1,     8'h44, 2'd3, 1'b1, 1'b0, 4'b1000, 1'b1);
        drain();
        bus.urg_req = 4'b0000;
        push("urg_hold3", U - 1, 8'h44, 2'd3, 1'b1, 1'b0, 4'b0000, 1'b1);
        push("resume_s1", D,     8'h22, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("resume_s3", D,     8'h44, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1);
        push("pre_drop_s0", 3,   8'h11, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        drain();

        // Valid drop at dwell cycle 3: advance next cycle
        bus.src_valid = 4'b1010;
        push("drop_adv_s1", 2, 8'h22, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drain();
        // Live tracking of the shown source's byte
        bus.src_data[15:8] = 8'h77;
        push("live_s1", 3, 8'h77, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drain();
        // All valid cleared: blank next cycle
        bus.src_valid = 4'b0000;
        push("all_drop_idle", 4, 8'h00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        drain();

        // Reset in the middle of URGENT, held request re-acked afterwards
        bus.urg_req = 4'b0001;
        push("urg_ack0",  1, 8'h11, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        push("urg_hold0", 4, 8'h11, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1);
        drain();
        rst = 1'b1;
        push("reset_mid_urg", 1, 8'h00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        drain();
        rst = 1'b0;
        push("reack0", 1, 8'h11, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        drain();
        bus.urg_req = 4'b0000;
        push("reack_hold0",   U - 1, 8'h11, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1);
        push("urg_exit_idle", 4,     8'h00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
